// File: rtl/camera_ctrl_pkg.sv
// Shared types, default constants and the saturating exposure-step helper
// for the camera exposure/readout controller.
package camera_pkg;

    localparam int EXP_W        = 5;
    localparam int CAM_EXP_MIN  = 2;
    localparam int CAM_EXP_MAX  = 30;
    localparam int CAM_EXP_INIT = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXPOSURE = 2'd1,
        ST_READOUT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PH_0 = 3'd0,
        PH_1 = 3'd1,
        PH_2 = 3'd2,
        PH_3 = 3'd3,
        PH_4 = 3'd4,
        PH_5 = 3'd5,
        PH_6 = 3'd6,
        PH_7 = 3'd7
    } phase_t;

    // One step up or down, clamped to [lo, hi]; opposing requests cancel.
    function automatic logic [EXP_W-1:0] exp_step(
        input logic [EXP_W-1:0] cur,
        input logic             up,
        input logic             dn,
        input logic [EXP_W-1:0] lo,
        input logic [EXP_W-1:0] hi
    );
        logic [EXP_W-1:0] res;
        if (up && !dn && (cur < hi)) begin
            res = cur + 5'd1;
        end else if (dn && !up && (cur > lo)) begin
            res = cur - 5'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/camera_ctrl_readout_seq.sv
// Two-row pixel readout sequencer: eight phases of READ_CYC cycles each,
// started by a go pulse; done is high during the final readout cycle.
module readout_seq
    import camera_pkg::*;
#(
    parameter int READ_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic nre_1,
    output logic nre_2,
    output logic adc,
    output logic done
);

    localparam int CW = (READ_CYC > 1) ? $clog2(READ_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_CYC - 1);

    logic          active_q, active_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nre_1_q, nre_1_d;
    logic          nre_2_q, nre_2_d;
    logic          adc_q, adc_d;
    logic          last_s;

    // Phase/cycle counting and the strobes for the upcoming cycle.
    always_comb begin
        last_s   = active_q && (phase_q == PH_7) && (cnt_q == CNT_LAST);
        active_d = active_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        if (go) begin
            active_d = 1'b1;
            phase_d  = PH_0;
            cnt_d    = {CW{1'b0}};
        end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = {CW{1'b0}};
                if (phase_q == PH_7) begin
                    active_d = 1'b0;
                    phase_d  = PH_0;
                end else begin
                    phase_d = phase_t'(phase_q + 3'd1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            active_d = 1'b0;
        end

        nre_1_d = 1'b1;
        nre_2_d = 1'b1;
        adc_d   = 1'b0;
        if (active_d) begin
            case (phase_d)
                PH_0, PH_2: nre_1_d = 1'b0;
                PH_1: begin
                    nre_1_d = 1'b0;
                    adc_d   = 1'b1;
                end
                PH_4, PH_6: nre_2_d = 1'b0;
                PH_5: begin
                    nre_2_d = 1'b0;
                    adc_d   = 1'b1;
                end
                default: begin
                    nre_1_d = 1'b1;
                    nre_2_d = 1'b1;
                end
            endcase
        end else begin
            adc_d = 1'b0;
        end
    end

    // Sequencer state and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            phase_q  <= PH_0;
            cnt_q    <= {CW{1'b0}};
            nre_1_q  <= 1'b1;
            nre_2_q  <= 1'b1;
            adc_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            nre_1_q  <= nre_1_d;
            nre_2_q  <= nre_2_d;
            adc_q    <= adc_d;
        end
    end

    assign nre_1 = nre_1_q;
    assign nre_2 = nre_2_q;
    assign adc   = adc_q;
    assign done  = last_s;

endmodule

// File: rtl/camera_ctrl.sv
// Camera exposure/readout controller. Optional exposure watchdog with a
// sticky Fault output is enabled by defining CAMERA_CTRL_WDT_EN.
module camera_ctrl
    import camera_pkg::*;
#(
    parameter int EXP_MIN  = CAM_EXP_MIN,
    parameter int EXP_MAX  = CAM_EXP_MAX,
    parameter int EXP_INIT = CAM_EXP_INIT,
    parameter int READ_CYC = 2
`ifdef CAMERA_CTRL_WDT_EN
    ,
    parameter int WDT_CYC  = 4096
`endif
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    input  logic             Ovf5,
    output logic             Start,
    output logic             Initial,
    output logic [EXP_W-1:0] Exp_time,
    output logic             Erase,
    output logic             Expose,
    output logic             NRE_1,
    output logic             NRE_2,
    output logic             ADC
`ifdef CAMERA_CTRL_WDT_EN
    ,
    output logic             Fault
`endif
);

    localparam logic [EXP_W-1:0] EXP_MIN_V  = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] EXP_MAX_V  = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_INIT_V = EXP_W'(EXP_INIT);

    state_t           state_q, state_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             inc_prev_q, dec_prev_q;
    logic             start_q, start_d;
    logic             erase_q, erase_d;
    logic             expose_q, expose_d;
    logic             inc_rise_s, dec_rise_s;
    logic             ovf_ok_s, go_s, seq_done_s;

`ifdef CAMERA_CTRL_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYC);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             fault_q, fault_d;
    logic             wdt_hit_s;
`endif

    // Top-level sequencing, exposure adjust and registered pixel controls.
    always_comb begin
        inc_rise_s = Exp_increase & ~inc_prev_q;
        dec_rise_s = Exp_decrease & ~dec_prev_q;
        // The timer is only loaded once Start/Initial has been seen.
        ovf_ok_s   = (state_q == ST_EXPOSURE) && Ovf5 && !start_q;
`ifdef CAMERA_CTRL_WDT_EN
        wdt_hit_s  = (state_q == ST_EXPOSURE) && (wdt_cnt_q == WDT_LAST);
        go_s       = ovf_ok_s | wdt_hit_s;
        wdt_cnt_d  = ((state_q == ST_EXPOSURE) && !go_s) ? (wdt_cnt_q + WDT_W'(1))
                                                          : {WDT_W{1'b0}};
        fault_d    = fault_q | (wdt_hit_s & ~ovf_ok_s);
`else
        go_s       = ovf_ok_s;
`endif
        state_d = state_q;
        exp_d   = exp_q;
        start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Init) begin
                    state_d = ST_EXPOSURE;
                    start_d = 1'b1;
                end else begin
                    exp_d = exp_step(exp_q, inc_rise_s, dec_rise_s, EXP_MIN_V, EXP_MAX_V);
                end
            end
            ST_EXPOSURE: begin
                if (go_s) begin
                    state_d = ST_READOUT;
                end else begin
                    state_d = ST_EXPOSURE;
                end
            end
            ST_READOUT: begin
                if (seq_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        erase_d  = (state_d == ST_IDLE);
        expose_d = (state_d == ST_EXPOSURE);
    end

    // FSM state, exposure register, edge history and registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            exp_q      <= EXP_INIT_V;
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
            start_q    <= 1'b0;
            erase_q    <= 1'b1;
            expose_q   <= 1'b0;
`ifdef CAMERA_CTRL_WDT_EN
            wdt_cnt_q  <= {WDT_W{1'b0}};
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            inc_prev_q <= Exp_increase;
            dec_prev_q <= Exp_decrease;
            start_q    <= start_d;
            erase_q    <= erase_d;
            expose_q   <= expose_d;
`ifdef CAMERA_CTRL_WDT_EN
            wdt_cnt_q  <= wdt_cnt_d;
            fault_q    <= fault_d;
`endif
        end
    end

    readout_seq #(
        .READ_CYC (READ_CYC)
    ) u_readout (
        .clk   (clk),
        .rst_n (Reset),
        .go    (go_s),
        .nre_1 (NRE_1),
        .nre_2 (NRE_2),
        .adc   (ADC),
        .done  (seq_done_s)
    );

    assign Start    = start_q;
    assign Initial  = start_q;
    assign Exp_time = exp_q;
    assign Erase    = erase_q;
    assign Expose   = expose_q;
`ifdef CAMERA_CTRL_WDT_EN
    assign Fault    = fault_q;
`endif

endmodule

// File: tb/tb_camera_ctrl.sv
// Self-checking bench for camera_ctrl: vector table, directed corner cases
// and random stimulus against a cycle-level behavioural model.
module tb_camera_ctrl;

    localparam int RC     = 2;
    localparam int RD_LEN = 8 * RC;
    localparam int WDT    = 64;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Init = 1'b0, Exp_increase = 1'b0, Exp_decrease = 1'b0, Ovf5 = 1'b0;
    logic       Start, Initial, Erase, Expose, NRE_1, NRE_2, ADC, Fault;
    logic [4:0] Exp_time;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0 idle, 1 exposing, 2 reading out.
    int m_mode, m_age, m_rd, m_exp;
    bit m_pinc, m_pdec, m_fault;

    typedef struct packed {
        logic        init, inc, dec, ovf;
        logic [10:0] exp;
    } vec_t;
    vec_t tbl [14];

    camera_ctrl #(
        .READ_CYC (RC)
`ifdef CAMERA_CTRL_WDT_EN
        , .WDT_CYC (WDT)
`endif
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Init         (Init),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .Ovf5         (Ovf5),
        .Start        (Start),
        .Initial      (Initial),
        .Exp_time     (Exp_time),
        .Erase        (Erase),
        .Expose       (Expose),
        .NRE_1        (NRE_1),
        .NRE_2        (NRE_2),
        .ADC          (ADC)
`ifdef CAMERA_CTRL_WDT_EN
        , .Fault      (Fault)
`endif
    );
`ifndef CAMERA_CTRL_WDT_EN
    assign Fault = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic i, input logic u, input logic d, input logic o,
                                input logic st, input logic er, input logic ex,
                                input logic n1, input logic n2, input logic a, input int e);
        return {i, u, d, o, st, er, ex, n1, n2, a, 5'(e)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {Fault, Start, Initial, Erase, Expose, NRE_1, NRE_2, ADC, Exp_time};
    endfunction

    function automatic logic [12:0] model_vec();
        int   ph;
        logic n1, n2, a, st;
        n1 = 1'b1; n2 = 1'b1; a = 1'b0;
        if (m_mode == 2) begin
            ph = m_rd / RC;
            n1 = !(ph <= 2);
            n2 = !(ph >= 4 && ph <= 6);
            a  = (ph == 1) || (ph == 5);
        end
        st = (m_mode == 1) && (m_age == 0);
        return {m_fault, st, st, m_mode == 0, m_mode == 1, n1, n2, a, 5'(m_exp)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_rd = 0; m_exp = 10;
        m_pinc = 1'b0; m_pdec = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_step(input bit init, input bit inc, input bit dec, input bit ovf);
        bit ie, de;
        ie = inc && !m_pinc;
        de = dec && !m_pdec;
        m_pinc = inc;
        m_pdec = dec;
        case (m_mode)
            0: begin
                if (init) begin
                    m_mode = 1; m_age = 0;
                end else if (ie && !de) begin
                    m_exp = (m_exp + 1 > 30) ? 30 : m_exp + 1;
                end else if (de && !ie) begin
                    m_exp = (m_exp - 1 < 2) ? 2 : m_exp - 1;
                end
            end
            1: begin
                if (ovf && m_age > 0) begin
                    m_mode = 2; m_rd = 0;
                end
`ifdef CAMERA_CTRL_WDT_EN
                else if (m_age == WDT - 1) begin
                    m_mode = 2; m_rd = 0; m_fault = 1'b1;
                end
`endif
                else begin
                    m_age++;
                end
            end
            default: begin
                if (m_rd == RD_LEN - 1) m_mode = 0;
                else m_rd++;
            end
        endcase
    endtask

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit init, input bit inc, input bit dec, input bit ovf);
        Init = init; Exp_increase = inc; Exp_decrease = dec; Ovf5 = ovf;
        @(posedge clk);
        model_step(init, inc, dec, ovf);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        Init = 1'b0; Exp_increase = 1'b0; Exp_decrease = 1'b0; Ovf5 = 1'b0;
        Reset = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();
        #1;
        check("reset_values", dut_vec(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd10});
        Reset = 1'b1;
    endtask

    initial begin
        logic [10:0] got;
        tbl[0]  = mk(0,0,0,0, 0,1,0,1,1,0, 10);
        tbl[1]  = mk(0,1,0,0, 0,1,0,1,1,0, 11);
        tbl[2]  = mk(0,1,0,0, 0,1,0,1,1,0, 11);
        tbl[3]  = mk(0,0,0,0, 0,1,0,1,1,0, 11);
        tbl[4]  = mk(0,1,1,0, 0,1,0,1,1,0, 11);
        tbl[5]  = mk(0,0,0,0, 0,1,0,1,1,0, 11);
        tbl[6]  = mk(0,0,1,0, 0,1,0,1,1,0, 10);
        tbl[7]  = mk(1,0,0,0, 1,0,1,1,1,0, 10);
        tbl[8]  = mk(0,0,0,1, 0,0,1,1,1,0, 10);
        tbl[9]  = mk(0,1,0,0, 0,0,1,1,1,0, 10);
        tbl[10] = mk(0,0,0,1, 0,0,0,0,1,0, 10);
        tbl[11] = mk(0,1,0,0, 0,0,0,0,1,0, 10);
        tbl[12] = mk(1,0,0,0, 0,0,0,0,1,1, 10);
        tbl[13] = mk(0,0,0,0, 0,0,0,0,1,1, 10);

        do_reset();
        repeat (3) begin
            cyc(0, 0, 0, 0);
            check("no_pulse_after_reset", {11'd0, Start, Initial}, 13'd0);
        end

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].init, tbl[i].inc, tbl[i].dec, tbl[i].ovf);
            got = {Start, Erase, Expose, NRE_1, NRE_2, ADC, Exp_time};
            check($sformatf("vec%0d", i), {2'b00, got}, {2'b00, tbl[i].exp});
        end
        repeat (RD_LEN - 4) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("idle_after_first_readout", {8'd0, Erase, Exp_time}, {8'd0, 1'b1, 5'd10});

        // Init and increase edge together: exposure starts, value kept.
        cyc(1, 1, 0, 0);
        check("init_beats_adjust", {7'd0, Start, Expose, Exp_time}, {7'd0, 1'b1, 1'b1, 5'd10});
        repeat (19) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        for (int c = 0; c < RD_LEN; c++) begin
            if (c > 0) cyc((c == RD_LEN - 1) ? 1'b1 : 1'b0, 0, 0, 0);
            check($sformatf("readout_c%0d", c), {9'd0, Expose, NRE_1, NRE_2, ADC},
                  {9'd0, 1'b0, (c < 6) ? 1'b0 : 1'b1, (c >= 8 && c <= 13) ? 1'b0 : 1'b1,
                   (c == 2 || c == 3 || c == 10 || c == 11) ? 1'b1 : 1'b0});
        end
        // Init held high across the end of readout.
        cyc(1, 0, 0, 0);
        check("idle_before_retrigger", {11'd0, Erase, Start}, {11'd0, 1'b1, 1'b0});
        cyc(1, 0, 0, 0);
        check("retrigger", {11'd0, Start, Expose}, {11'd0, 1'b1, 1'b1});
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // Now in phase p1: reset must act before the next clock edge.
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check("async_reset_p1", dut_vec(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd10});
        @(posedge clk);
        #1;
        Reset = 1'b1;

        repeat (25) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 0, 0);
        end
        check("sat_max", {8'd0, Exp_time}, 13'd30);
        repeat (35) begin
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0);
        end
        check("sat_min", {8'd0, Exp_time}, 13'd2);
        cyc(0, 1, 1, 0);
        check("both_edges", {8'd0, Exp_time}, 13'd2);
        cyc(0, 0, 0, 1);
        check("stray_ovf_idle", {11'd0, Erase, Expose}, {11'd0, 1'b1, 1'b0});

`ifdef CAMERA_CTRL_WDT_EN
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (WDT - 1) cyc(0, 0, 0, 0);
        check("wdt_not_early", {10'd0, Expose, NRE_1, Fault}, {10'd0, 1'b1, 1'b1, 1'b0});
        cyc(0, 0, 0, 0);
        check("wdt_timeout", {10'd0, Expose, NRE_1, Fault}, {10'd0, 1'b0, 1'b0, 1'b1});
        repeat (RD_LEN) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        repeat (RD_LEN) cyc(0, 0, 0, 0);
        check("fault_sticky", {12'd0, Fault}, 13'd1);
        do_reset();
        check("fault_cleared", {12'd0, Fault}, 13'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/camera_ctrl.md
Name: camera_ctrl

Overview:
- Exposure/readout control FSM for the camera; sits directly upstream of the exposure timer.
- Holds the programmable exposure time and drives the timer's Start/Initial inputs.
- Consumes the timer's Ovf5 expiry pulse, then sequences the two-row pixel readout (NRE_1/NRE_2/ADC) back to idle.

Parameters:
- EXP_MIN, 2, minimum exposure value (timer units).
- EXP_MAX, 30, maximum exposure value.
- EXP_INIT, 10, exposure value after reset.
- READ_CYC, 2, clock cycles per readout phase (>=1).
- WDT_CYC, 4096, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Init  in  1  request one exposure+readout cycle; level, honoured only in IDLE.
- Exp_increase  in  1  button level; rising edge increments the exposure.
- Exp_decrease  in  1  button level; rising edge decrements the exposure.
- Ovf5  in  1  timer expiry pulse.
- Start  out  1  one-cycle pulse that starts the timer.
- Initial  out  1  one-cycle pulse that loads Exp_time into the timer.
- Exp_time  out  5  current exposure value.
- Erase  out  1  pixel erase; high in IDLE.
- Expose  out  1  pixel expose; high in EXPOSURE.
- NRE_1  out  1  row-1 read enable, active-low.
- NRE_2  out  1  row-2 read enable, active-low.
- ADC  out  1  ADC sample strobe.

Behaviour:
- All outputs registered.
- Reset (Reset=0, asynchronous) values: state=IDLE, Exp_time=EXP_INIT, Erase=1, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Start=0, Initial=0. Edge-detect registers are cleared.
- States: IDLE -> EXPOSURE -> READOUT -> IDLE.
- IDLE:
  - Init=1 -> EXPOSURE on the next edge. In the first EXPOSURE cycle, Initial=1 and Start=1 (both exactly one cycle).
  - Erase=1 throughout IDLE.
- Exposure adjust (IDLE only):
  - A rising edge of Exp_increase adds 1 to Exp_time; a rising edge of Exp_decrease subtracts 1.
  - Saturates at EXP_MAX / EXP_MIN; no wrap.
  - Both edges in the same cycle -> no change.
  - Init in the same cycle wins; the adjust is dropped.
  - Edges seen outside IDLE are ignored and not queued.
- EXPOSURE:
  - Erase=0, Expose=1.
  - Ovf5=1 -> READOUT next cycle and Expose=0.
  - Ovf5 in the same cycle as Initial/Start is ignored; the timer has not yet loaded.
- READOUT: 8 phases of READ_CYC cycles each, driven by a phase counter.
  - p0: NRE_1=0.
  - p1: NRE_1=0, ADC=1.
  - p2: NRE_1=0.
  - p3: idle.
  - p4: NRE_2=0.
  - p5: NRE_2=0, ADC=1.
  - p6: NRE_2=0.
  - p7: idle.
  - After p7 -> IDLE, Erase=1.
  - Total readout = 8*READ_CYC cycles. Init held high re-triggers only after IDLE has been entered (minimum one IDLE cycle).
- Ovf5 outside EXPOSURE: ignored.
- Reset mid-operation: immediate return to reset values. No Start/Initial pulse is emitted on reset release.

Optional Feature:
- Macro: CAMERA_CTRL_WDT_EN.
- Defined:
  - Adds output Fault (1 bit, reset 0).
  - A cycle counter runs in EXPOSURE. Reaching WDT_CYC without Ovf5 forces READOUT and sets Fault (sticky until Reset).
- Undefined: no Fault port and no counter; EXPOSURE waits indefinitely for Ovf5.

Decomposition:
- Package camera_pkg:
  - State encoding (IDLE/EXPOSURE/READOUT).
  - Readout phase encoding p0..p7.
  - Default constants EXP_MIN/EXP_MAX/EXP_INIT.
  - Exp_time width (5).
- Sub-module readout_seq:
  - Inputs: go pulse.
  - Outputs: NRE_1/NRE_2/ADC and a done pulse.
  - Owns the phase and READ_CYC counters.
- camera_ctrl keeps the top FSM, the exposure register and the edge detectors.

Test Plan:
- Reset held 3 cycles then released, no stimulus -> Exp_time=10, Erase=1, NRE_1=NRE_2=1, ADC=0, no Start/Initial pulse.
- Init pulse in IDLE -> next cycle Initial=Start=1 for exactly 1 cycle, Expose=1, Erase=0. Ovf5 after 20 cycles -> Expose=0. With READ_CYC=2: NRE_1 low 6 cycles, ADC high on readout cycles 2-3, NRE_2 low on cycles 8-13, ADC high on cycles 10-11, IDLE after 16 cycles.
- 25 Exp_increase edges from reset -> Exp_time saturates at 30. 35 Exp_decrease edges -> saturates at 2. Simultaneous inc+dec edges -> unchanged.
- Exp_increase edge during EXPOSURE and READOUT -> Exp_time unchanged after returning to IDLE. Init and Exp_increase edge in the same IDLE cycle -> exposure starts, Exp_time unchanged.
- Reset asserted in READOUT phase p1 -> outputs return to reset values asynchronously (before the next clk edge). Stray Ovf5 in IDLE -> no state change.
- With CAMERA_CTRL_WDT_EN and WDT_CYC=64, no Ovf5 -> READOUT entered after 64 EXPOSURE cycles, Fault=1 and held through a later normal cycle until Reset.
